lfsr_rr_server: RTL and testbench
=================================

# lfsr_rr_server

Round-robin server that shares one 8-bit many-to-one LFSR among `N_REQ` requesters. Each grant advances the LFSR by `STEPS` shifts and hands the resulting byte to exactly one requester with a one-cycle `valid`. The block sits between the pseudo-random source and the lab's consumers (pattern generators, test stimulus), and it owns seeding and lock-up protection.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `STEPS`, 8: LFSR shifts per delivered value, 1..15.
- `SEED`, 8'hBD: reset state, and the substitute for any all-zero seed.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in N_REQ: level request, one bit per requester.
- `seed_load` in 1: pulse to load `seed_data`; honoured only when `ready`.
- `seed_data` in 8: new LFSR state.
- `ready` out 1: high in IDLE.
- `gnt` out N_REQ: one-hot grant, valid with `valid`.
- `valid` out 1: one-cycle strobe; `data` is meaningful this cycle.
- `data` out 8: delivered LFSR value.

## Operation
- LFSR core: feedback `fb = s[7]^s[3]^s[2]^s[1]`, next state `{s[6:0], fb}`. This is the polynomial x^8+x^4+x^3+x^2+1, with period 255.
- FSM has three states: IDLE, STEP, DELIVER.
- **IDLE**
  - If `seed_load` is high: load `seed_data`, or `SEED` if `seed_data==0`. Stay in IDLE. `req` is ignored that cycle.
  - Else if `req!=0`: latch the winner and go to STEP with `cnt=STEPS-1`.
  - Winner is the first set bit at or after `ptr`, searching cyclically upward.
- **STEP**
  - Shift once per cycle.
  - When `cnt==0`, go to DELIVER; otherwise decrement `cnt`.
- **DELIVER**
  - Register outputs: `data`=LFSR state, `gnt`=one-hot winner, `valid`=1.
  - Set `ptr`=winner+1, modulo N_REQ.
  - Return to IDLE.
- Requests are sampled only in IDLE.
  - A requester dropping `req` after arbitration still receives its grant.
  - A requester not granted must hold `req`; nothing is queued.
- `seed_load` outside IDLE is ignored; no error flag is raised.
- Reset values:
  - State = IDLE, LFSR = `SEED`, `ptr`=0, `cnt`=0.
  - `gnt`=0, `valid`=0, `data`=8'h00, `ready`=1 once reset deasserts.
- Reset asserted mid-operation aborts immediately: the pending grant is lost and all registers return to reset values asynchronously.
- The LFSR never reaches zero. Seeds pass through zero-substitution, and a nonzero state stays nonzero.

## Timing
- Arbitration edge k (IDLE, `req!=0`) to `valid` high: the cycle after edge k+STEPS+1.
- `valid` lasts exactly one cycle. `ready` is low from edge k until `valid` has been seen.
- Back-to-back requests: IDLE is re-entered the cycle after DELIVER, giving one delivery per STEPS+2 cycles.
- `seed_load` at edge k: the new state is visible to the next arbitration at edge k+1 or later.
- `gnt`, `valid` and `data` are registered with no combinational path from inputs.
- `data` holds its last value outside DELIVER.

## Configuration
- `LFSR_RR_STATS_EN` defined:
  - Adds output `grant_cnt` (16 bits): the count of deliveries.
  - Increments in DELIVER, saturates at 16'hFFFF, resets to 0.
- Undefined: no port, no counter; behaviour is otherwise identical.

## Structure
- Package `lfsr_pkg` holds:
  - the FSM state typedef (IDLE, STEP, DELIVER);
  - `LFSR_W=8`;
  - the default seed constant 8'hBD;
  - the tap positions.
- Sub-module `lfsr8_core`: state register, load port, step enable and zero-substitution.
- The top level holds the FSM, round-robin pointer, step counter and output registers.

## Test plan
Benches use STEPS=1, N_REQ=4 unless stated otherwise.
- Reset, then a single `req=4'b0001` → `valid` arrives 2 cycles after the arbitration edge, with `gnt=0001`, `data=8'h7B`.
- `req=4'b1111` held continuously → grants in order 0001, 0010, 0100, 1000, 0001, with data 7B, F6, ED, …; `valid` every 3 cycles.
- `seed_load` with `seed_data=8'h00` in IDLE, then a request → `data=8'h7B`, proving the zero seed was replaced by BD.
- `seed_load` asserted during STEP → ignored, and the delivered sequence is unchanged. `rst_n` dropped in STEP → `valid` never fires and the next delivery is 7B again.
- STEPS=8, 255 consecutive deliveries from one requester → all values nonzero, no repeats within the 255 × 8 shift span, and the state returns to BD after 255 shifts.
- With `LFSR_RR_STATS_EN` defined: 10 deliveries → `grant_cnt=10`. Force the counter to 16'hFFFE and make 3 more deliveries → `grant_cnt=16'hFFFF`.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants, FSM state type and next-state helper for the
// lfsr_rr_server block and its lfsr8_core sub-module.
package lfsr_pkg;

   localparam int LFSR_W = 8;

   // power-up state and the replacement for an all-zero seed
   localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'hBD;

   // feedback taps for x^8+x^4+x^3+x^2+1: bits 7, 3, 2 and 1 are XORed
   localparam logic [LFSR_W-1:0] TAP_MASK = 8'b1000_1110;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STEP    = 2'd1,
      DELIVER = 2'd2
   } state_t;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], ^(s & TAP_MASK)};
   endfunction

endpackage

// File: rtl/lfsr8_core.sv
// lfsr8_core: 8-bit many-to-one LFSR register with a seed load port, a
// single-shift enable and zero-seed substitution so the state never locks up.
module lfsr8_core
   import lfsr_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_data,
   input  logic              step,
   output logic [LFSR_W-1:0] state
);

   // load has priority over step; an all-zero seed is replaced by SEED
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SEED;
      end else if (load) begin
         state <= (load_data == '0) ? SEED : load_data;
      end else if (step) begin
         state <= lfsr_next(state);
      end
   end

endmodule

// File: rtl/lfsr_rr_server.sv
// lfsr_rr_server: round-robin server sharing one LFSR among N_REQ requesters.
// Each grant shifts the LFSR STEPS times and delivers the byte with a
// one-cycle valid strobe. Optional macro LFSR_RR_STATS_EN adds a saturating
// 16-bit delivery counter on output grant_cnt.
module lfsr_rr_server
   import lfsr_pkg::*;
#(
   parameter int                N_REQ = 4,
   parameter int                STEPS = 8,
   parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_REQ-1:0]  req,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_data,
   output logic              ready,
   output logic [N_REQ-1:0]  gnt,
   output logic              valid,
   output logic [LFSR_W-1:0] data
`ifdef LFSR_RR_STATS_EN
   ,
   output logic [15:0]       grant_cnt
`endif
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t            state;
   logic [PTR_W-1:0]  ptr;
   logic [PTR_W-1:0]  winner;
   logic [PTR_W-1:0]  pick;
   logic [3:0]        cnt;
   logic [LFSR_W-1:0] lfsr_state;
   logic              lfsr_load;
   logic              lfsr_step;

   assign lfsr_load = (state == IDLE) && seed_load;
   assign lfsr_step = (state == STEP);
   assign ready     = (state == IDLE);

   lfsr8_core #(
      .SEED(SEED)
   ) u_core (
      .clk(clk),
      .rst_n(rst_n),
      .load(lfsr_load),
      .load_data(seed_data),
      .step(lfsr_step),
      .state(lfsr_state)
   );

   // cyclic search for the first requesting bit at or after ptr
   always_comb begin
      int               idx;
      logic             found;
      logic [PTR_W-1:0] pos;
      pick  = ptr;
      found = 1'b0;
      idx   = 0;
      pos   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         pos = idx[PTR_W-1:0];
         if (!found && req[pos]) begin
            found = 1'b1;
            pick  = pos;
         end
      end
   end

   // control FSM: arbitrate in IDLE, shift in STEP, register outputs in DELIVER
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         ptr    <= '0;
         winner <= '0;
         cnt    <= '0;
         gnt    <= '0;
         valid  <= 1'b0;
         data   <= '0;
      end else begin
         valid <= 1'b0;
         gnt   <= '0;
         case (state)
            IDLE: begin
               if (!seed_load && (req != '0)) begin
                  winner <= pick;
                  cnt    <= 4'(STEPS - 1);
                  state  <= STEP;
               end
            end
            STEP: begin
               if (cnt == '0) begin
                  state <= DELIVER;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DELIVER: begin
               data  <= lfsr_state;
               gnt   <= N_REQ'(1) << winner;
               valid <= 1'b1;
               ptr   <= (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef LFSR_RR_STATS_EN
   // saturating count of completed deliveries
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt <= '0;
      end else if ((state == DELIVER) && (grant_cnt != 16'hFFFF)) begin
         grant_cnt <= grant_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_lfsr_rr_server.sv
// tb_lfsr_rr_server: self-checking bench for lfsr_rr_server. Instance u_dut
// uses STEPS=1, instance u_dut8 uses STEPS=8 for the full-period run.
// Honours LFSR_RR_STATS_EN when defined.
module tb_lfsr_rr_server;

   localparam int N_REQ    = 4;
   localparam int STEPS    = 1;
   localparam int STEPS8   = 8;
   localparam int WAIT_MAX = 40;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b1;
   logic [N_REQ-1:0] req   = '0;
   logic             seed_load = 1'b0;
   logic [7:0]       seed_data = '0;
   logic             ready;
   logic [N_REQ-1:0] gnt;
   logic             valid;
   logic [7:0]       data;

   logic [N_REQ-1:0] req8 = '0;
   logic             seed_load8 = 1'b0;
   logic [7:0]       seed_data8 = '0;
   logic             ready8;
   logic [N_REQ-1:0] gnt8;
   logic             valid8;
   logic [7:0]       data8;

`ifdef LFSR_RR_STATS_EN
   logic [15:0]      grant_cnt;
   logic [15:0]      grant_cnt8;
`endif

   int checks = 0;
   int errors = 0;
   int m_lfsr = 'hBD;
   int m_ptr  = 0;

   typedef struct {
      logic       do_seed;
      logic [7:0] sd;
      logic [3:0] r;
      logic [3:0] eg;
      logic [7:0] ed;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   lfsr_rr_server #(.N_REQ(N_REQ), .STEPS(STEPS), .SEED(8'hBD)) u_dut (
      .clk(clk), .rst_n(rst_n), .req(req), .seed_load(seed_load),
      .seed_data(seed_data), .ready(ready), .gnt(gnt), .valid(valid),
      .data(data)
`ifdef LFSR_RR_STATS_EN
      , .grant_cnt(grant_cnt)
`endif
   );

   lfsr_rr_server #(.N_REQ(N_REQ), .STEPS(STEPS8), .SEED(8'hBD)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .req(req8), .seed_load(seed_load8),
      .seed_data(seed_data8), .ready(ready8), .gnt(gnt8), .valid(valid8),
      .data(data8)
`ifdef LFSR_RR_STATS_EN
      , .grant_cnt(grant_cnt8)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // one polynomial shift computed from the feedback rule with plain arithmetic
   function automatic int modelShift(input int s);
      int fb;
      fb = ((s >> 7) ^ (s >> 3) ^ (s >> 2) ^ (s >> 1)) & 1;
      return ((s << 1) | fb) & 'hFF;
   endfunction

   function automatic void modelSeed(input int sd);
      m_lfsr = (sd == 0) ? 'hBD : sd;
   endfunction

   task automatic modelDeliver(input logic [3:0] r, output int eg, output int ed);
      int w;
      int b;
      w = -1;
      for (int i = 0; i < N_REQ; i++) begin
         b = (m_ptr + i) % N_REQ;
         if (w < 0 && (((r >> b) & 4'd1) != 4'd0)) begin
            w = b;
         end
      end
      for (int s = 0; s < STEPS; s++) begin
         m_lfsr = modelShift(m_lfsr);
      end
      eg     = (w < 0) ? 0 : (1 << w);
      ed     = m_lfsr;
      m_ptr  = (w + 1) % N_REQ;
   endtask

   task automatic doReset();
      rst_n     = 1'b0;
      req       = '0;
      seed_load = 1'b0;
      seed_data = '0;
      req8      = '0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      m_lfsr = 'hBD;
      m_ptr  = 0;
   endtask

   // optional seed cycle (request also driven, must be ignored), then one arbitration
   task automatic applyStimulus(input logic do_seed, input logic [7:0] sd,
                                input logic [3:0] r, output int lat,
                                output logic [3:0] got_gnt, output logic [7:0] got_data);
      if (do_seed) begin
         seed_load = 1'b1;
         seed_data = sd;
         req       = r;
         tick();
         seed_load = 1'b0;
      end
      req = r;
      tick();
      checkOutput("ready_low_after_arb", ready, 0);
      req = '0;
      lat = -1;
      for (int n = 1; n <= WAIT_MAX; n++) begin
         tick();
         if (valid) begin
            lat = n;
            break;
         end
      end
      got_gnt  = gnt;
      got_data = data;
      if (lat > 0) begin
         checkOutput("ready_at_valid", ready, 1);
      end
      tick();
      checkOutput("valid_one_cycle", valid, 0);
      checkOutput("data_hold", data, got_data);
   endtask

   task automatic runAndCheck(input string tag, input logic do_seed, input logic [7:0] sd,
                              input logic [3:0] r, input int eg, input int ed);
      int         lat;
      logic [3:0] g;
      logic [7:0] d;
      applyStimulus(do_seed, sd, r, lat, g, d);
      checkOutput({tag, "_latency"}, lat, STEPS + 1);
      checkOutput({tag, "_gnt"}, g, eg);
      checkOutput({tag, "_data"}, d, ed);
   endtask

   task automatic runModel(input string tag, input logic do_seed, input logic [7:0] sd,
                           input logic [3:0] r);
      int eg;
      int ed;
      if (do_seed) begin
         modelSeed(sd);
      end
      modelDeliver(r, eg, ed);
      runAndCheck(tag, do_seed, sd, r, eg, ed);
   endtask

   initial begin
      int         eg;
      int         ed;
      int         vcount;
      int         hits;
      int         lat;
      logic [3:0] exp_g;
      int         s8;
      int         zeros;
      int         reps;
      int         last;
      bit         seen[256];
      logic [3:0] rnd_req;
      logic [7:0] rnd_sd;
      logic       rnd_seed;

      vecs.push_back('{1'b0, 8'h00, 4'b0001, 4'b0001, 8'h7B});
      vecs.push_back('{1'b0, 8'h00, 4'b1111, 4'b0010, 8'hF6});
      vecs.push_back('{1'b0, 8'h00, 4'b0001, 4'b0001, 8'hED});
      vecs.push_back('{1'b1, 8'h00, 4'b1000, 4'b1000, 8'h7B});
      vecs.push_back('{1'b1, 8'h80, 4'b0110, 4'b0010, 8'h01});
      vecs.push_back('{1'b0, 8'h00, 4'b0110, 4'b0100, 8'h02});
      vecs.push_back('{1'b0, 8'h00, 4'b0110, 4'b0010, 8'h05});

      // reset values
      doReset();
      checkOutput("reset_ready", ready, 1);
      checkOutput("reset_valid", valid, 0);
      checkOutput("reset_gnt", gnt, 0);
      checkOutput("reset_data", data, 0);
`ifdef LFSR_RR_STATS_EN
      checkOutput("reset_grant_cnt", grant_cnt, 0);
`endif

      // table-driven vectors
      foreach (vecs[i]) begin
         if (vecs[i].do_seed) begin
            modelSeed(vecs[i].sd);
         end
         modelDeliver(vecs[i].r, eg, ed);
         runAndCheck($sformatf("vec%0d", i), vecs[i].do_seed, vecs[i].sd,
                     vecs[i].r, vecs[i].eg, vecs[i].ed);
      end

      // back-to-back with all requests held: delivery every STEPS+2 cycles
      doReset();
      req    = 4'b1111;
      vcount = 0;
      for (int t = 1; t <= 15; t++) begin
         tick();
         if (valid) begin
            modelDeliver(4'b1111, eg, ed);
            exp_g = 4'(1 << (vcount % 4));
            checkOutput($sformatf("b2b%0d_cycle", vcount), t, 3 * (vcount + 1));
            checkOutput($sformatf("b2b%0d_gnt", vcount), gnt, exp_g);
            checkOutput($sformatf("b2b%0d_data", vcount), data, ed);
            vcount++;
         end
      end
      req = '0;
      checkOutput("b2b_count", vcount, 5);
      tick();

      // seed_load during STEP must be ignored
      modelDeliver(4'b0010, eg, ed);
      req = 4'b0010;
      tick();
      req       = '0;
      seed_load = 1'b1;
      seed_data = 8'h55;
      tick();
      seed_load = 1'b0;
      lat = -1;
      for (int n = 2; n <= WAIT_MAX; n++) begin
         tick();
         if (valid) begin
            lat = n;
            break;
         end
      end
      checkOutput("seed_in_step_latency", lat, STEPS + 1);
      checkOutput("seed_in_step_data", data, ed);
      tick();
      runModel("after_seed_in_step", 1'b0, 8'h00, 4'b1111);

      // reset during STEP aborts the pending grant asynchronously
      req = 4'b0100;
      tick();
      req   = '0;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_async_ready", ready, 1);
      checkOutput("rst_async_valid", valid, 0);
      tick();
      tick();
      rst_n = 1'b1;
      m_lfsr = 'hBD;
      m_ptr  = 0;
      vcount = 0;
      for (int n = 0; n < 6; n++) begin
         tick();
         if (valid) vcount++;
      end
      checkOutput("rst_no_valid", vcount, 0);
      runAndCheck("after_rst", 1'b0, 8'h00, 4'b0001, 4'b0001, 8'h7B);
      modelDeliver(4'b0001, eg, ed);

      // randomized transactions against the reference model
      for (int k = 0; k < 40; k++) begin
         rnd_req  = 4'($urandom_range(1, 15));
         rnd_seed = ($urandom_range(0, 3) == 0);
         rnd_sd   = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 4) == 0) rnd_sd = 8'h00;
         runModel($sformatf("rnd%0d", k), rnd_seed, rnd_sd, rnd_req);
      end

      // STEPS=8 instance: 255 deliveries cover the whole period
      doReset();
      s8    = 'hBD;
      zeros = 0;
      reps  = 0;
      last  = -1;
      foreach (seen[i]) seen[i] = 1'b0;
      req8 = 4'b0100;
      for (int k = 0; k < 255; k++) begin
         hits = 0;
         for (int n = 0; n < WAIT_MAX; n++) begin
            tick();
            if (valid8) begin
               hits = 1;
               break;
            end
         end
         if (hits == 0) begin
            checkOutput("s8_timeout", 0, 1);
            break;
         end
         for (int s = 0; s < STEPS8; s++) s8 = modelShift(s8);
         checkOutput($sformatf("s8_data%0d", k), data8, s8);
         checkOutput($sformatf("s8_gnt%0d", k), gnt8, 4'b0100);
         if (data8 == 8'h00) zeros++;
         if (seen[data8]) reps++;
         seen[data8] = 1'b1;
         last = data8;
      end
      req8 = '0;
      checkOutput("s8_no_zero", zeros, 0);
      checkOutput("s8_no_repeat", reps, 0);
      checkOutput("s8_back_to_seed", last, 'hBD);
      tick();

`ifdef LFSR_RR_STATS_EN
      // delivery counter and saturation
      doReset();
      for (int k = 0; k < 10; k++) begin
         runModel($sformatf("stat%0d", k), 1'b0, 8'h00, 4'($urandom_range(1, 15)));
      end
      checkOutput("grant_cnt_10", grant_cnt, 10);
      force u_dut.grant_cnt = 16'hFFFE;
      tick();
      release u_dut.grant_cnt;
      for (int k = 0; k < 3; k++) begin
         runModel($sformatf("sat%0d", k), 1'b0, 8'h00, 4'($urandom_range(1, 15)));
      end
      checkOutput("grant_cnt_sat", grant_cnt, 'hFFFF);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
